// File: rtl/turbo_pkg.sv
// Shared definitions for the NB-IoT turbo receive checker and encoder side:
// RSC generator polynomials, trellis tail length, FSM encoding and legal K range.
package turbo_pkg;

    // Generator polynomials, MSB = D^0 ... LSB = D^3.
    // G0 = 1 + D^2 + D^3 (feedback), G1 = 1 + D + D^3 (parity).
    localparam logic [3:0] G0 = 4'b1011;
    localparam logic [3:0] G1 = 4'b1101;

    // Number of trellis termination steps for a 3-register RSC.
    localparam int TAIL_LEN = 3;

    // Legal information block lengths (also multiple of 8).
    localparam int K_MIN = 40;
    localparam int K_MAX = 6144;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        TAIL = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/turbo_rx_checker_if.sv
// Serial rate-1/3 stream handshake: one systematic bit and two parity bits
// per transfer, qualified by in_valid and accepted when in_ready is high.
interface turbo_rx_checker_if;

    logic in_valid;
    logic in_ready;
    logic sys_in;
    logic par1_in;
    logic par2_in;

    modport master (
        output in_valid,
        output sys_in,
        output par1_in,
        output par2_in,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  sys_in,
        input  par1_in,
        input  par2_in,
        output in_ready
    );

endinterface

// File: rtl/rsc_step.sv
// One combinational step of the rate-1/2 recursive systematic convolutional
// encoder. In tail mode the input bit is replaced by the value that zeroes the
// feedback, so the state drains towards 000; o_sys reports the bit actually
// used (the input in data mode, the termination bit in tail mode).
module rsc_step
    import turbo_pkg::*;
(
    input  logic       i_u,
    input  logic       i_tail,
    input  logic [2:0] i_state,   // {s1, s2, s3}
    output logic       o_sys,
    output logic       o_par,
    output logic [2:0] o_next
);

    logic w_fb_taps;
    logic w_par_taps;
    logic w_fb;

    assign w_fb_taps  = ^(i_state & G0[2:0]);
    assign w_par_taps = ^(i_state & G1[2:0]);

    assign o_sys  = i_tail ? w_fb_taps : i_u;
    assign w_fb   = o_sys ^ w_fb_taps;
    assign o_par  = w_fb ^ w_par_taps;
    assign o_next = {w_fb, i_state[2:1]};

endmodule

// File: rtl/turbo_rx_checker.sv
// Receive-side turbo stream checker: rebuilds the K-bit information block,
// buffers the RSC2 parity, and re-encodes the systematic stream with a local
// RSC1 to count parity-1 errors and verify trellis termination.
module turbo_rx_checker
    import turbo_pkg::*;
#(
    parameter int K    = 2560,
    parameter int ERRW = 12
) (
    input  logic               clk,
    input  logic               rst,
    turbo_rx_checker_if.slave  s_in,
    output logic [0:K-1]       dout,
    output logic [0:K-1]       par2_buf,
    output logic               blk_done,
    output logic [ERRW-1:0]    par1_err_cnt,
    output logic               term_ok
);

    localparam int               IDX_W     = $clog2(K);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(K - 1);
    localparam logic [1:0]       LAST_TAIL = 2'(TAIL_LEN - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDX_W-1:0]  r_idx;
    logic [1:0]        r_tcnt;
    logic [2:0]        r_rsc;
    logic [0:K-1]      r_dout;
    logic [0:K-1]      r_par2;
    logic [ERRW-1:0]   r_err;
    logic              r_term;

    logic              w_in_ready;
    logic              w_blk_done;
    logic              w_acc;
    logic              w_tail;
    logic [2:0]        w_rsc_cur;
    logic [2:0]        w_rsc_nxt;
    logic              w_sys_exp;
    logic              w_par_exp;
    logic              w_mis;

    // Saturating increment: the counter sticks at all-ones.
    function automatic logic [ERRW-1:0] sat_inc(input logic [ERRW-1:0] v,
                                                input logic            en);
        if (en && (v != {ERRW{1'b1}}))
            return v + ERRW'(1);
        return v;
    endfunction

    assign w_acc          = s_in.in_valid & w_in_ready;
    assign s_in.in_ready  = w_in_ready;
    assign w_tail         = (r_state == TAIL);
    // A fresh block always starts from the all-zero trellis state.
    assign w_rsc_cur      = (r_state == IDLE) ? 3'b000 : r_rsc;

    rsc_step u_rsc1 (
        .i_u     (s_in.sys_in),
        .i_tail  (w_tail),
        .i_state (w_rsc_cur),
        .o_sys   (w_sys_exp),
        .o_par   (w_par_exp),
        .o_next  (w_rsc_nxt)
    );

    // In data mode w_sys_exp equals sys_in, so only parity can disagree;
    // in tail mode both the termination bit and its parity are checked.
    assign w_mis = (w_par_exp ^ s_in.par1_in) | (w_sys_exp ^ s_in.sys_in);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // FSM next-state and handshake/status outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_blk_done  = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_in_ready = rst;
                if (w_acc)
                    w_state_nxt = DATA;
            end
            DATA: begin
                w_in_ready = rst;
                if (w_acc && (r_idx == LAST_IDX))
                    w_state_nxt = TAIL;
            end
            TAIL: begin
                w_in_ready = rst;
                if (w_acc && (r_tcnt == LAST_TAIL))
                    w_state_nxt = DONE;
            end
            DONE: begin
                w_blk_done  = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Block buffers, trellis state, error counter and termination flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_idx  <= '0;
            r_tcnt <= '0;
            r_rsc  <= '0;
            r_dout <= '0;
            r_par2 <= '0;
            r_err  <= '0;
            r_term <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_acc) begin
                        r_dout[0] <= s_in.sys_in;
                        r_par2[0] <= s_in.par2_in;
                        r_err     <= sat_inc('0, w_mis);
                        r_term    <= 1'b1;
                        r_rsc     <= w_rsc_nxt;
                        r_idx     <= IDX_W'(1);
                    end
                end
                DATA: begin
                    if (w_acc) begin
                        r_dout[r_idx] <= s_in.sys_in;
                        r_par2[r_idx] <= s_in.par2_in;
                        r_err         <= sat_inc(r_err, w_mis);
                        r_rsc         <= w_rsc_nxt;
                        if (r_idx == LAST_IDX) begin
                            r_idx  <= '0;
                            r_tcnt <= '0;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                TAIL: begin
                    if (w_acc) begin
                        r_err  <= sat_inc(r_err, w_mis);
                        r_rsc  <= w_rsc_nxt;
                        r_tcnt <= r_tcnt + 2'd1;
                        if (w_mis)
                            r_term <= 1'b0;
                    end
                end
                DONE: begin
                    r_rsc  <= '0;
                    r_tcnt <= '0;
                end
                default: ;
            endcase
        end
    end

    assign dout         = r_dout;
    assign par2_buf     = r_par2;
    assign par1_err_cnt = r_err;
    assign term_ok      = r_term;
    assign blk_done     = w_blk_done;

endmodule
